// File: rtl/cpu_mem_pkg.sv
// Shared constants and types for the CPU memory path.
// Provides the responder FSM state encoding, the exception-vector addresses
// the address-select path can present, the captured request payload and a
// small byte-lane helper.
package cpu_mem_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 4;   // holds LATENCY-1 for LATENCY up to 15

    // Responder FSM encoding, shared with the rest of the CPU
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;

    // Exception vectors selectable on the address path
    localparam logic [XLEN-1:0] EXC_VEC_0 = 32'd253;
    localparam logic [XLEN-1:0] EXC_VEC_1 = 32'd254;
    localparam logic [XLEN-1:0] EXC_VEC_2 = 32'd255;

    // Request fields captured on acceptance
    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } mem_req_t;

    // Byte lane k of a little-endian word
    function automatic logic [7:0] word_byte(input logic [XLEN-1:0] w, input logic [1:0] k);
        return w[{k, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mem_byte_array.sv
// Byte-addressed storage with four independent read and write ports.
// Ports:
//   clk_i    - clock; writes occur on its rising edge
//   we_i     - per-port write enable
//   waddr_i  - per-port write byte address
//   wdata_i  - per-port write byte
//   raddr_i  - per-port read byte address
//   rdata_o  - per-port read byte (combinational)
// Contents are not reset.
module mem_byte_array #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                clk_i,
    input  logic [3:0]          we_i,
    input  logic [3:0][AW-1:0]  waddr_i,
    input  logic [3:0][7:0]     wdata_i,
    input  logic [3:0][AW-1:0]  raddr_i,
    output logic [3:0][7:0]     rdata_o
);

    logic [7:0] mem_q [DEPTH];

    // Synchronous byte writes; callers never target one byte from two ports
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < 4; k++) begin
            if (we_i[k]) begin
                mem_q[waddr_i[k]] <= wdata_i[k];
            end
        end
    end

    // Combinational reads
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            rdata_o[k] = mem_q[raddr_i[k]];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Word-wide memory responder with fixed access latency.
// Accepts one request at a time in IDLE, waits LATENCY cycles in BUSY,
// performs the access on leaving BUSY and pulses resp_valid for one cycle.
// Words are little-endian; byte addresses wrap modulo DEPTH.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   req_valid/req_ready   - request handshake
//   req_we/addr/wdata     - request fields (write flag, byte address, data)
//   resp_valid            - one-cycle response pulse
//   resp_rdata/resp_err   - read data, rejection flag (0 when resp_valid=0)
// Build option: MEM_RESPONDER_ALIGN_CHECK_EN rejects addresses with addr[1:0]!=0.
module mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    mem_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    mem_req_t           req_q;
    logic               req_ready_q;
    logic               resp_valid_q;
    logic               resp_err_q;
    logic [XLEN-1:0]    resp_rdata_q;

    logic               req_bad_c;
    logic               access_c;
    logic [3:0][AW-1:0] byte_addr_c;
    logic [3:0]         byte_we_c;
    logic [3:0][7:0]    byte_wdata_c;
    logic [3:0][7:0]    byte_rdata_c;
    logic               resp_err_d;
    logic [XLEN-1:0]    resp_rdata_d;

    // Rejection decode on the captured request
    always_comb begin
        req_bad_c = (req_q.addr >= 32'(DEPTH));
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        req_bad_c = req_bad_c | (req_q.addr[1:0] != 2'b00);
`endif
    end

    // Last BUSY cycle: the edge ending it performs the access
    assign access_c = (state_q == ST_BUSY) && (cnt_q == '0);

    // Byte lanes; the AW-bit add wraps modulo DEPTH
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            byte_addr_c[k]  = req_q.addr[AW-1:0] + AW'(k);
            byte_wdata_c[k] = word_byte(req_q.wdata, 2'(k));
            byte_we_c[k]    = access_c && req_q.we && !req_bad_c;
        end
    end

    assign resp_err_d   = req_bad_c;
    assign resp_rdata_d = (req_q.we || req_bad_c) ? '0 : XLEN'(byte_rdata_c);

    mem_byte_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (byte_we_c),
        .waddr_i (byte_addr_c),
        .wdata_i (byte_wdata_c),
        .raddr_i (byte_addr_c),
        .rdata_o (byte_rdata_c)
    );

    // Handshake FSM with registered outputs; response fields default to 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            req_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            unique case (state_q)
                ST_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        req_q.we    <= req_we;
                        req_q.addr  <= req_addr;
                        req_q.wdata <= req_wdata;
                        cnt_q       <= CNT_W'(LATENCY - 1);
                        req_ready_q <= 1'b0;
                        state_q     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt_q == '0) begin
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= resp_err_d;
                        resp_rdata_q <= resp_rdata_d;
                        state_q      <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    req_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    req_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder (DEPTH=256, LATENCY=2): directed requests with
// literal expectations plus a cycle-level reference model compared on every cycle.
module tb_mem_responder;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned LAT   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_total = 0;
    int n_bad   = 0;

    mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  model_mem [DEPTH];
    bit          pend;
    int          edge_n, acc_edge;
    logic        m_we;
    logic [31:0] m_addr, m_wdata;
    logic        exp_ready, exp_valid, exp_err;
    logic [31:0] exp_rdata;

    function automatic bit m_bad(input logic [31:0] a);
        bit b;
        b = (a >= 32'(DEPTH));
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        b = b || (a[1:0] != 2'b00);
`endif
        return b;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = model_mem[(a + 32'(k)) % DEPTH];
        return w;
    endfunction

    // Request accepted at edge a answers after edge a+LAT, ready returns after edge a+LAT+1
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pend      <= 1'b0;
            edge_n    <= 0;
            exp_ready <= 1'b1;
            exp_valid <= 1'b0;
            exp_err   <= 1'b0;
            exp_rdata <= '0;
        end else begin
            edge_n    <= edge_n + 1;
            exp_valid <= 1'b0;
            exp_err   <= 1'b0;
            exp_rdata <= '0;
            if (!pend) begin
                if (req_valid) begin
                    pend      <= 1'b1;
                    acc_edge  <= edge_n;
                    m_we      <= req_we;
                    m_addr    <= req_addr;
                    m_wdata   <= req_wdata;
                    exp_ready <= 1'b0;
                end
            end else if (edge_n == acc_edge + int'(LAT)) begin
                exp_valid <= 1'b1;
                exp_err   <= m_bad(m_addr);
                exp_rdata <= (m_we || m_bad(m_addr)) ? 32'h0 : m_read(m_addr);
                if (m_we && !m_bad(m_addr)) begin
                    for (int k = 0; k < 4; k++)
                        model_mem[(m_addr + 32'(k)) % DEPTH] <= m_wdata[8*k +: 8];
                end
            end else if (edge_n == acc_edge + int'(LAT) + 1) begin
                pend      <= 1'b0;
                exp_ready <= 1'b1;
            end
        end
    end

    // Cycle-by-cycle comparison away from the active edge
    always @(negedge clk) begin
        check("cmp_ready", 32'(req_ready), 32'(exp_ready));
        check("cmp_valid", 32'(resp_valid), 32'(exp_valid));
        check("cmp_err", 32'(resp_err), 32'(exp_err));
        check("cmp_rdata", resp_rdata, exp_rdata);
    end

    // ---------------- directed stimulus ----------------
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat);
        int  k;
        bit  got;
        rd = '0; er = 1'b0; lat = -1;
        @(negedge clk); #1;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        k = 0;
        while (!req_ready && k < 50) begin
            @(negedge clk); #1;
            k++;
        end
        if (!req_ready) begin
            check("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        got = 1'b0;
        for (int i = 1; i <= 20 && !got; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                got = 1'b1; lat = i; rd = resp_rdata; er = resp_err;
            end
        end
        if (!got) check("resp_timeout", 32'(got), 32'd1);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n_acc, n_resp, run, got_resp;

        // Reset state
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", 32'(resp_err), 32'd0);

        // Preset every word; byte 0 = 0x44
        for (int i = 0; i < 64; i++)
            do_req(1'b1, 32'(4*i), (i == 0) ? 32'hCAFE0044 : 32'h10203040 + 32'(i) * 32'h01010101,
                   rd, er, lat);

        // Write then read 0x10
        do_req(1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat);
        check("wr10_lat", 32'(lat), 32'd3);
        check("wr10_err", 32'(er), 32'd0);
        check("wr10_rdata", rd, 32'd0);
        do_req(1'b0, 32'h10, 32'h0, rd, er, lat);
        check("rd10_lat", 32'(lat), 32'd3);
        check("rd10_rdata", rd, 32'hDEADBEEF);
        check("rd10_err", 32'(er), 32'd0);

        // Read wrapping past the top of memory
        do_req(1'b1, 32'd252, 32'h11223344, rd, er, lat);
        do_req(1'b0, 32'd253, 32'h0, rd, er, lat);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        check("rd253_err", 32'(er), 32'd1);
        check("rd253_rdata", rd, 32'd0);
`else
        check("rd253_err", 32'(er), 32'd0);
        check("rd253_rdata", rd, 32'h44112233);
`endif

        // Out of range write is rejected and changes nothing
        do_req(1'b1, 32'd256, 32'hFFFFFFFF, rd, er, lat);
        check("oor_err", 32'(er), 32'd1);
        check("oor_rdata", rd, 32'd0);
        do_req(1'b1, 32'hFFFFFFFC, 32'hFFFFFFFF, rd, er, lat);
        check("oor_hi_err", 32'(er), 32'd1);
        do_req(1'b0, 32'd0, 32'h0, rd, er, lat);
        check("rd0_after_oor", rd, 32'hCAFE0044);

        // Write wrapping past the top of memory
        do_req(1'b1, 32'd254, 32'hA1B2C3D4, rd, er, lat);
        do_req(1'b0, 32'd0, 32'h0, rd, er, lat);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        check("wrap_wr_rd0", rd, 32'hCAFE0044);
`else
        check("wrap_wr_rd0", rd, 32'hCAFEA1B2);
`endif

        // Reset in the middle of BUSY discards the write
        @(negedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h55AA55AA;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk); #1;
        reset = 1'b1;
        @(negedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 32'd1);
        got_resp = 0;
        for (int i = 0; i < 6; i++) begin
            if (resp_valid) got_resp++;
            @(negedge clk);
        end
        check("post_rst_no_resp", 32'(got_resp), 32'd0);
        do_req(1'b0, 32'h20, 32'h0, rd, er, lat);
        check("rd20_after_rst", rd, 32'h18283848);

        // req_valid held high while the address changes every cycle
        n_acc = 0; n_resp = 0; run = 0;
        @(negedge clk); #1;
        for (int i = 0; i < 24; i++) begin
            req_valid = 1'b1;
            req_we    = i[0];
            req_addr  = 32'h80 + 32'(4 * (i % 8));
            req_wdata = 32'h0BAD0000 + 32'(i);
            @(negedge clk);
            if (resp_valid) n_resp++;
            if (req_ready) begin
                n_acc++;
                if (run > 0) check("ready_low_run", 32'(run), 32'd3);
                run = 0;
            end else begin
                run++;
            end
            #1;
        end
        req_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (resp_valid) n_resp++;
        end
        check("stream_accepts", 32'(n_acc), 32'd6);
        check("stream_resps", 32'(n_resp), 32'd6);

`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
        do_req(1'b0, 32'h11, 32'h0, rd, er, lat);
        check("align_11_err", 32'(er), 32'd1);
        check("align_11_rdata", rd, 32'd0);
        do_req(1'b0, 32'h10, 32'h0, rd, er, lat);
        check("align_10_err", 32'(er), 32'd0);
        check("align_10_rdata", rd, 32'hDEADBEEF);
`else
        do_req(1'b0, 32'h11, 32'h0, rd, er, lat);
        check("unalign_11_err", 32'(er), 32'd0);
        check("unalign_11_rdata", rd, 32'h45DEADBE);
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning memory size in bytes (power of two, 16..65536).
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles between request acceptance and response (1..15).
REQ-003 SHALL have ports: clk  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have ports: reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: req_valid  input  1  initiator presents a request.
REQ-006 SHALL have ports: req_ready  output  1  responder can accept a request.
REQ-007 SHALL have ports: req_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have ports: req_addr  input  32  byte address from the address-select path (PC, ALU result or exception vector).
REQ-009 SHALL have ports: req_wdata  input  32  write data.
REQ-010 SHALL have ports: resp_valid  output  1  one-cycle pulse; response fields valid.
REQ-011 SHALL have ports: resp_rdata  output  32  read data; 0 for writes and errors.
REQ-012 SHALL have ports: resp_err  output  1  request was rejected; no state changed.

Function
REQ-013 SHALL accept a request on a rising edge where req_valid && req_ready, capturing we, addr and wdata.
REQ-014 SHALL implement FSM IDLE -> BUSY -> RESP -> IDLE: IDLE has req_ready=1; acceptance moves to BUSY with counter=LATENCY-1; BUSY decrements the counter; at 0 it moves to RESP; RESP drives resp_valid=1 for exactly one cycle, then returns to IDLE.
REQ-015 SHALL perform the memory access on the BUSY->RESP transition, so acceptance-to-resp_valid latency is exactly LATENCY+1 cycles.
REQ-016 SHALL hold req_ready=0 in BUSY and RESP; no back-to-back acceptance (minimum 3-cycle request spacing).
REQ-017 SHALL store bytes little-endian: word byte k is at address (addr+k) mod DEPTH, k=0..3.
REQ-018 SHALL wrap multi-byte accesses modulo DEPTH; e.g. addr=DEPTH-3 touches DEPTH-3, DEPTH-2, DEPTH-1, 0.
REQ-019 SHALL flag resp_err=1 when req_addr >= DEPTH, suppress the write, and return resp_rdata=0.
REQ-020 SHALL return resp_rdata=0 for writes.
REQ-021 SHALL hold resp_rdata and resp_err at 0 whenever resp_valid=0.
REQ-022 SHALL ignore changes on req_* while not in IDLE.

Reset
REQ-023 SHALL, on reset asserted at any time (including mid-access), force state IDLE, counter 0, req_ready=1 after release, resp_valid=0, resp_rdata=0, resp_err=0, and discard any in-flight request (no write performed).
REQ-024 SHALL NOT clear memory contents on reset; contents are undefined after power-up.

Configuration
REQ-025 SHALL, with MEM_RESPONDER_ALIGN_CHECK_EN defined, additionally flag resp_err=1 (no write, rdata 0) when req_addr[1:0] != 0.
REQ-026 SHALL, without MEM_RESPONDER_ALIGN_CHECK_EN, accept unaligned addresses using the byte-wrap rules of REQ-017/REQ-018.

Structure
REQ-027 SHALL take the FSM state encoding (IDLE=2'd0, BUSY=2'd1, RESP=2'd2) and exception-vector constants (253, 254, 255) from shared package cpu_mem_pkg.
REQ-028 SHALL place the byte array in sub-module mem_byte_array (4 read ports, 4 write ports with per-byte enable, synchronous write, combinational read).

Verification
REQ-029 SHALL pass: reset; write 0xDEADBEEF to addr 0x10, then read 0x10 -> resp_valid exactly 3 cycles after each acceptance (LATENCY=2), rdata=0xDEADBEEF, err=0.
REQ-030 SHALL pass: read byte-wrap case: write 0x11223344 at 252; then, with the align check off, read 253 -> rdata=0x44112233 (bytes 253, 254, 255, 0; byte 0 preset to 0x44).
REQ-031 SHALL pass: out-of-range case: write 0xFFFFFFFF to addr 256 -> err=1, rdata=0; a subsequent read of 0 shows unchanged data.
REQ-032 SHALL pass: reset mid-BUSY during write to 0x20 -> no resp_valid, memory at 0x20 unchanged, req_ready=1 on the first cycle after release.
REQ-033 SHALL pass: hold req_valid=1 continuously with changing addresses -> accept only in IDLE, one response per acceptance, req_ready low for exactly LATENCY+1 cycles after each acceptance.
REQ-034 SHALL pass: with MEM_RESPONDER_ALIGN_CHECK_EN, read addr 0x11 -> err=1, rdata=0; read addr 0x10 -> err=0.
